// File: rtl/task_sequencer.sv
// Programmable motion-step sequencer: walks a runtime-writable table of (command, duration)
// steps, counting slow tick enables, with pause/resume, abort and optional loop mode.
module task_sequencer #(
  parameter int unsigned NUM_STEPS = 4,
  parameter int unsigned CMD_WIDTH = 2,
  parameter int unsigned DUR_WIDTH = 4,
  parameter bit          LOOP      = 1'b0,
  localparam int unsigned SW       = $clog2(NUM_STEPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 pause,
  input  logic                 tick,
  input  logic                 prog_we,
  input  logic [SW-1:0]        prog_addr,
  input  logic [CMD_WIDTH-1:0] prog_cmd,
  input  logic [DUR_WIDTH-1:0] prog_dur,
  output logic [CMD_WIDTH-1:0] cmd,
  output logic [SW-1:0]        step_idx,
  output logic [1:0]           state,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               state_q;
  logic [CMD_WIDTH-1:0] tbl_cmd [NUM_STEPS];
  logic [DUR_WIDTH-1:0] tbl_dur [NUM_STEPS];
  logic [DUR_WIDTH-1:0] remaining;

  logic                 last_c;
  logic                 advance_c;
  logic                 prog_ok_c;
  logic [SW-1:0]        next_idx_c;
  logic [CMD_WIDTH-1:0] next_cmd_c;
  logic [CMD_WIDTH-1:0] first_cmd_c;
  logic [CMD_WIDTH-1:0] cur_cmd_c;

  // Step-advance decode; a zero-duration step shows cmd 0 and advances without a tick
  always_comb begin
    last_c      = (step_idx == SW'(NUM_STEPS - 1));
    next_idx_c  = last_c ? '0 : step_idx + SW'(1);
    next_cmd_c  = (tbl_dur[next_idx_c] == '0) ? '0 : tbl_cmd[next_idx_c];
    first_cmd_c = (tbl_dur[0] == '0) ? '0 : tbl_cmd[0];
    cur_cmd_c   = (remaining == '0) ? '0 : tbl_cmd[step_idx];
    advance_c   = (remaining == '0) || (tick && (remaining == DUR_WIDTH'(1)));
    prog_ok_c   = prog_we && !start && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  assign state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cmd       <= '0;
      step_idx  <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int unsigned i = 0; i < NUM_STEPS; i++) begin
        tbl_cmd[i] <= '0;
        tbl_dur[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (prog_ok_c) begin
        tbl_cmd[prog_addr] <= prog_cmd;
        tbl_dur[prog_addr] <= prog_dur;
      end
      if (abort) begin
        state_q   <= S_IDLE;
        cmd       <= '0;
        step_idx  <= '0;
        remaining <= '0;
        busy      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              state_q   <= S_RUN;
              busy      <= 1'b1;
              step_idx  <= '0;
              remaining <= tbl_dur[0];
              cmd       <= first_cmd_c;
            end
          end
          S_RUN: begin
            if (pause) begin
              state_q <= S_PAUSED;
              cmd     <= '0;
            end else if (advance_c) begin
              if (last_c && !LOOP) begin
                state_q   <= S_DONE;
                busy      <= 1'b0;
                cmd       <= '0;
                remaining <= '0;
                done      <= 1'b1;
              end else begin
                step_idx  <= next_idx_c;
                remaining <= tbl_dur[next_idx_c];
                cmd       <= next_cmd_c;
                done      <= last_c;
              end
            end else if (tick) begin
              remaining <= remaining - DUR_WIDTH'(1);
            end
          end
          S_PAUSED: begin
            // Resume cycle consumes no tick
            if (!pause) begin
              state_q <= S_RUN;
              cmd     <= cur_cmd_c;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/task_sequencer.md
# task_sequencer

Parametrised, programmable successor to the robot task manager: runs a table of up to NUM_STEPS motion steps. Each step holds a command code and a duration in `tick` periods (the slow enable, e.g. 1 Hz), and the sequencer drives the selected command to the motor/PWM layer. Adds pause/resume, abort, loop mode and a runtime-writable step table. Sits between the top-level control FSM and the drive blocks.

## Interface
- NUM_STEPS, 4: number of table entries, ≥2; SW = clog2(NUM_STEPS)
- CMD_WIDTH, 2: command code width; code 0 = stop/idle
- DUR_WIDTH, 4: step duration width, in ticks
- LOOP, 0: 1 = wrap from last step to step 0 instead of finishing

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins sequence from IDLE or DONE
- abort  in  1  one-cycle pulse; return to IDLE from any state
- pause  in  1  level; holds sequence while high
- tick  in  1  timing enable, one clk cycle wide; each high cycle counts once
- prog_we  in  1  table write strobe
- prog_addr  in  SW  table entry index
- prog_cmd  in  CMD_WIDTH  command to store
- prog_dur  in  DUR_WIDTH  duration to store
- cmd  out  CMD_WIDTH  active command (registered)
- step_idx  out  SW  current step index
- state  out  2  0 IDLE, 1 RUN, 2 PAUSED, 3 DONE
- busy  out  1  high in RUN or PAUSED
- done  out  1  one-cycle pulse at sequence end / wrap

## Operation
- Reset (asynchronous, while reset low): state IDLE, cmd 0, step_idx 0, busy 0, done 0, remaining-count 0, all table entries cleared to cmd 0 / dur 0.
- Priority per cycle: abort > pause > start > tick.
- IDLE/DONE: cmd 0. start → RUN, step_idx 0, remaining = dur[0], cmd = cmd[0] (cmd 0 if dur[0] = 0). DONE: abort → IDLE.
- RUN: on tick: remaining > 1 → decrement; remaining = 1 → advance. start ignored.
- Zero-duration step: occupies exactly one clk cycle with cmd 0, consumes no tick, then advances.
- Advance: step_idx < NUM_STEPS−1 → next step, load its dur/cmd. Last step: LOOP=0 → DONE, cmd 0, done pulse; LOOP=1 → step 0, stay RUN, done pulse.
- pause high in RUN → PAUSED: cmd forced 0, ticks ignored, remaining and step_idx held. pause low → RUN, cmd restored from current step, countdown continues.
- abort in any state → IDLE, cmd 0, step_idx 0, remaining 0; table preserved.
- prog_we accepted only when state is IDLE or DONE and start is low; otherwise dropped silently. Table is not readable back.
- Counter widths: remaining is DUR_WIDTH bits; no wrap possible (only decremented while > 1).

## Timing
- All outputs registered; every change is visible one clk after the causing edge (start, tick, pause edge, abort).
- Step boundary: cmd of next step appears the cycle after the tick that ends the current step; a D-tick step therefore shows its cmd for exactly D tick periods (±1 clk).
- done high for exactly one cycle, same cycle state enters DONE (or step_idx wraps to 0).
- Tick coincident with pause assertion: ignored. Tick coincident with pause release: ignored (resume cycle consumes none).
- Table write takes effect the cycle after prog_we; a write and start in the same cycle: write dropped, start proceeds on old table.
- Reset mid-operation: outputs clear immediately (asynchronous), no done pulse.

## Test plan
- Program {1/3, 2/2, 3/1, 1/2} (cmd/dur), start, 8 ticks 20 clk apart → cmd 1,1,1,2,2,3,1,1 per tick period; done pulses 1 cycle after 8th tick; state 3, cmd 0.
- Same table, pause high after 1st tick of step 1 for 100 clk with 5 ticks inside → state 2, cmd 0, step_idx 1 held; after release, step 1 ends on the 1st following tick.
- Abort during step 2 → next cycle state 0, cmd 0, step_idx 0; start again → cmd 1 from step 0 with full dur 3.
- LOOP=1, table {1/1, 2/1, 3/1, 1/1}, 9 ticks → step_idx 0,1,2,3,0,1,2,3,0; done pulses after ticks 4 and 8; state stays 1.
- Table {1/2, 2/0, 3/1, 1/1} → step 1 lasts exactly 1 clk with cmd 0, step 2 (cmd 3) begins without a tick.
- prog_we to entry 0 (cmd 3) during RUN → ignored, next run still starts with cmd 1; pull reset low mid-RUN → cmd, state, busy 0 within same cycle, table entries cleared.
